// File: rtl/ahb_lite_manager.sv
// Single-transfer AHB-Lite manager: turns one command into one NONSEQ/SINGLE transfer,
// absorbing wait states, the two-cycle ERROR response and a stalled-subordinate timeout.
module ahb_lite_manager #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [1:0]        hsize,
  output logic              hwrite,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hresp,
  input  logic              hready
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;

  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_timeout;

  assign cmd_ready = (r_state == S_IDLE);

  // Saturating stall count; the abort fires on the edge that would reach the limit.
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && !hready && (w_cnt_inc >= CNT_LIMIT);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_wdata     <= '0;
      r_cnt       <= '0;
      hsel        <= 1'b0;
      haddr       <= '0;
      htrans      <= HTRANS_IDLE;
      hsize       <= 2'b00;
      hwrite      <= 1'b0;
      hburst      <= 3'b000;
      hwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_wdata <= cmd_wdata;
            r_cnt   <= '0;
            hsel    <= 1'b1;
            htrans  <= HTRANS_NONSEQ;
            haddr   <= cmd_addr;
            hsize   <= cmd_size;
            hwrite  <= cmd_write;
            hburst  <= 3'b000;
            r_state <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (hready) begin
            r_cnt   <= '0;
            hsel    <= 1'b0;
            htrans  <= HTRANS_IDLE;
            hwdata  <= hwrite ? r_wdata : '0;
            r_state <= S_DATA;
          end else if (w_timeout) begin
            r_cnt       <= '0;
            hsel        <= 1'b0;
            htrans      <= HTRANS_IDLE;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_DATA: begin
          if (hready) begin
            // A single-cycle ERROR is a protocol violation but still reported as an error.
            r_cnt     <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= hresp;
            rsp_rdata <= (!hwrite && !hresp) ? hrdata : '0;
            r_state   <= S_IDLE;
          end else if (w_timeout) begin
            r_cnt       <= '0;
            hsel        <= 1'b0;
            htrans      <= HTRANS_IDLE;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
            if (hresp) begin
              r_state <= S_ERR;
            end
          end
        end

        S_ERR: begin
          if (hready) begin
            r_cnt <= '0;
            if (hresp) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              r_state   <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_cnt       <= '0;
            hsel        <= 1'b0;
            htrans      <= HTRANS_IDLE;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Bench for ahb_lite_manager: directed scenarios followed by randomized transfers, each
// checked cycle by cycle against a timeline derived from the transfer's wait/error profile.
module tb_ahb_lite_manager;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int T      = 8;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        cmd_size;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic [1:0]        hsize;
  logic              hwrite;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hresp;
  logic              hready;

  int checks = 0;
  int errors = 0;

  ahb_lite_manager #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
    .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hresp(hresp), .hready(hready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Subordinate behaviour {hready,hresp} at edge e (accept edge is 0): a address stalls,
  // d data stalls, then kind 0=OKAY, 1=two-cycle ERROR, 2=single-cycle ERROR.
  function automatic logic [1:0] bus_in(input int e, input int a, input int d, input int kind);
    int s;
    s = d + ((kind == 1) ? 1 : 0);
    if (e >= 1 && e <= a) return 2'b00;
    if (e == a + 1) return 2'b10;
    if (e <= a + 1 + d) return 2'b00;
    if (kind == 1 && e == a + 2 + d) return 2'b01;
    if (e == a + 2 + s) return {1'b1, kind != 0};
    return 2'b10;
  endfunction

  task automatic idle_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      hready    = 1'b1;
      hresp     = 1'b0;
      hrdata    = {$urandom, $urandom};
      step();
      chk($sformatf("%s idle%0d cmd_ready", name, i), 64'(cmd_ready), 64'(1'b1));
      chk($sformatf("%s idle%0d rsp_valid", name, i), 64'(rsp_valid), 64'(1'b0));
      chk($sformatf("%s idle%0d hsel", name, i), 64'(hsel), 64'(1'b0));
      chk($sformatf("%s idle%0d htrans", name, i), 64'(htrans), 64'(2'b00));
    end
  endtask

  task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                         input logic [63:0] wdata, input int a, input int d, input int kind,
                         input bit noise, input string name);
    int          s;
    int          addr_end;
    int          resp_cycle;
    bit          to;
    bit          addr_to;
    bit          exp_rsp;
    bit          exp_hsel;
    logic [63:0] rd_val;
    logic [63:0] exp_rdata;
    logic [1:0]  bi;

    s = d + ((kind == 1) ? 1 : 0);
    addr_to = (a >= T);
    if (addr_to) begin
      to = 1; addr_end = T; resp_cycle = T + 1;
    end else if (s >= T) begin
      to = 1; addr_end = a + 1; resp_cycle = a + 2 + T;
    end else begin
      to = 0; addr_end = a + 1; resp_cycle = a + 3 + s;
    end
    rd_val = '0;

    chk($sformatf("%s c0 cmd_ready", name), 64'(cmd_ready), 64'(1'b1));
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
    hready    = 1'b1;
    hresp     = 1'b0;
    hrdata    = {$urandom, $urandom};

    for (int cyc = 1; cyc <= resp_cycle; cyc++) begin
      step();
      exp_rsp   = (cyc == resp_cycle);
      exp_hsel  = (cyc <= addr_end);
      exp_rdata = (exp_rsp && !to && !wr && kind == 0) ? rd_val : 64'h0;

      chk($sformatf("%s c%0d cmd_ready", name, cyc), 64'(cmd_ready), 64'(exp_rsp));
      chk($sformatf("%s c%0d rsp_valid", name, cyc), 64'(rsp_valid), 64'(exp_rsp));
      chk($sformatf("%s c%0d rsp_err", name, cyc), 64'(rsp_err), 64'(exp_rsp && !to && kind != 0));
      chk($sformatf("%s c%0d rsp_timeout", name, cyc), 64'(rsp_timeout), 64'(exp_rsp && to));
      chk($sformatf("%s c%0d rsp_rdata", name, cyc), rsp_rdata, exp_rdata);
      chk($sformatf("%s c%0d hsel", name, cyc), 64'(hsel), 64'(exp_hsel));
      chk($sformatf("%s c%0d htrans", name, cyc), 64'(htrans), exp_hsel ? 64'h2 : 64'h0);
      chk($sformatf("%s c%0d hburst", name, cyc), 64'(hburst), 64'h0);
      if (exp_hsel) begin
        chk($sformatf("%s c%0d haddr", name, cyc), 64'(haddr), 64'(addr));
        chk($sformatf("%s c%0d hwrite", name, cyc), 64'(hwrite), 64'(wr));
        chk($sformatf("%s c%0d hsize", name, cyc), 64'(hsize), 64'(size));
      end
      if (!addr_to && cyc > addr_end && cyc < resp_cycle) begin
        chk($sformatf("%s c%0d hwdata", name, cyc), hwdata, wr ? wdata : 64'h0);
      end

      if (cyc < resp_cycle && noise && $urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom);
        cmd_addr  = ADDR_W'($urandom);
        cmd_wdata = {$urandom, $urandom};
      end else begin
        cmd_valid = 1'b0;
      end
      bi     = bus_in(cyc, a, d, kind);
      hready = bi[1];
      hresp  = bi[0];
      hrdata = {$urandom, $urandom};
      if (!to && cyc == a + 2 + s) rd_val = hrdata;
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] w;
    n_rst     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_size  = 2'b00;
    cmd_wdata = '0;
    hrdata    = '0;
    hresp     = 1'b0;
    hready    = 1'b1;

    step();
    step();
    chk("reset hsel", 64'(hsel), 64'h0);
    chk("reset htrans", 64'(htrans), 64'h0);
    chk("reset haddr", 64'(haddr), 64'h0);
    chk("reset hwdata", hwdata, 64'h0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset cmd_ready", 64'(cmd_ready), 64'h1);
    n_rst = 1'b1;
    step();

    run_txn(1'b1, 10'h008, 2'b11, 64'h0101_0101_0101_0101, 0, 0, 0, 0, "wr_dw");
    run_txn(1'b0, 10'h023, 2'b00, 64'h0, 0, 2, 0, 0, "rd_ws2");
    run_txn(1'b1, 10'h022, 2'b00, 64'h01, 0, 0, 1, 0, "err2");
    run_txn(1'b1, 10'h030, 2'b10, 64'hdead_beef, 1, 1, 2, 0, "err1");
    run_txn(1'b0, 10'h100, 2'b11, 64'h0, 20, 0, 0, 0, "to_addr");
    idle_cycles(1, "to_addr_after");
    run_txn(1'b0, 10'h104, 2'b11, 64'h0, 0, 20, 0, 0, "to_data");
    run_txn(1'b0, 10'h200, 2'b01, 64'h0, 1, 3, 0, 1, "busy");
    run_txn(1'b1, 10'h204, 2'b01, 64'h5a5a, 0, 7, 0, 1, "max_stall");

    for (int n = 0; n < 200; n++) begin
      int a;
      int d;
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 2);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 2);
      run_txn(1'($urandom), ADDR_W'($urandom), 2'($urandom), {$urandom, $urandom},
              a, d, $urandom_range(0, 2), 1'($urandom), $sformatf("rnd%0d", n));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2), $sformatf("rnd%0d_gap", n));
    end

    // Reset while the data phase of a write is stalled: no response may follow.
    w = 64'hcafe_f00d_1234_5678;
    idle_cycles(1, "rst_pre");
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h055; cmd_size = 2'b11; cmd_wdata = w;
    hready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("rst_mid addr hsel", 64'(hsel), 64'h1);
    step();
    chk("rst_mid data hwdata", hwdata, w);
    hready = 1'b0;
    step();
    step();
    chk("rst_mid stall rsp_valid", 64'(rsp_valid), 64'h0);
    n_rst = 1'b0;
    step();
    chk("rst_mid hsel", 64'(hsel), 64'h0);
    chk("rst_mid htrans", 64'(htrans), 64'h0);
    chk("rst_mid haddr", 64'(haddr), 64'h0);
    chk("rst_mid hwrite", 64'(hwrite), 64'h0);
    chk("rst_mid hsize", 64'(hsize), 64'h0);
    chk("rst_mid hwdata", hwdata, 64'h0);
    chk("rst_mid rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_mid rsp_rdata", rsp_rdata, 64'h0);
    n_rst = 1'b1;
    idle_cycles(3, "rst_post");
    run_txn(1'b0, 10'h3ff, 2'b11, 64'h0, 0, 1, 0, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
